// File: rtl/adder64_rr_sched.sv
// Round-robin front end sharing one pipelined 64-bit adder among NREQ requesters.
// Optional per-requester grant counters are enabled with `define ARB_STATS_EN.
module adder64_rr_sched #(
  parameter int NREQ      = 4,
  parameter int ADDER_LAT = 2,
  parameter int IDW       = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][63:0]      req_a,
  input  logic [NREQ-1:0][63:0]      req_b,
  input  logic                       drain,
  output logic                       idle,
  output logic                       add_valid,
  output logic [63:0]                add_a,
  output logic [63:0]                add_b,
  input  logic [63:0]                add_sum,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [63:0]                rsp_sum
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]      grant_cnt
`endif
);

  // The issue register plus TAG_D stages lines the tail tag up with add_sum.
  localparam int TAG_D = ADDER_LAT + 1;

  typedef enum logic [1:0] {RUN, DRAIN, EMPTY} state_e;
  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  state_e               state_q;
  logic [IDW-1:0]       rr_ptr_q, add_id_q;
  logic                 add_valid_q;
  logic [63:0]          add_a_q, add_b_q, rsp_sum_q;
  logic [NREQ-1:0]      rsp_valid_q;
  tag_t [TAG_D-1:0]     tag_q;

  logic                 found, hs, tag_busy;
  logic [IDW-1:0]       win;
  logic [NREQ-1:0]      gnt, rsp_oh;
  logic [63:0]          sel_a, sel_b;
  int                   idx;

  always_comb begin
    found = 1'b0;
    win   = rr_ptr_q;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
    gnt   = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        gnt[i] = found && (state_q == RUN) && !drain && !rst;
        sel_a  = req_a[i];
        sel_b  = req_b[i];
      end
    end
  end

  assign req_ready = gnt;
  assign hs        = |(req_valid & gnt);

  always_comb begin
    tag_busy = 1'b0;
    for (int s = 0; s < TAG_D; s++) tag_busy = tag_busy | tag_q[s].vld;
    rsp_oh = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_oh[i] = tag_q[TAG_D-1].vld && (tag_q[TAG_D-1].id == IDW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rr_ptr_q    <= IDW'(NREQ - 1);
      add_valid_q <= 1'b0;
      add_id_q    <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      case (state_q)
        RUN:     if (drain) state_q <= DRAIN;
        DRAIN:   if (!tag_busy && !add_valid_q) state_q <= EMPTY;
        EMPTY:   if (!drain) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      add_valid_q <= hs;
      if (hs) begin
        add_a_q  <= sel_a;
        add_b_q  <= sel_b;
        add_id_q <= win;
        rr_ptr_q <= win;
      end
      tag_q[0] <= '{vld: add_valid_q, id: add_id_q};
      for (int s = 1; s < TAG_D; s++) tag_q[s] <= tag_q[s-1];
      rsp_valid_q <= rsp_oh;
      if (tag_q[TAG_D-1].vld) rsp_sum_q <= add_sum;
    end
  end

  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign idle      = !rst && ((state_q == EMPTY) ||
                     (state_q == RUN && !tag_busy && !add_valid_q && (req_valid == '0)));

`ifdef ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        if (gnt[i] && req_valid[i] && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
  end
  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder64_rr_sched.sv
// Directed bench for adder64_rr_sched: reset, single op, contention, drain, mid-flight reset.
// With ARB_STATS_EN defined it also exercises grant counter saturation.
module tb_adder64_rr_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                  clk = 1'b0;
  logic                  rst, drain, idle, add_valid;
  logic [NREQ-1:0]       req_valid, req_ready, rsp_valid;
  logic [NREQ-1:0][63:0] req_a, req_b;
  logic [63:0]           add_a, add_b, add_sum, rsp_sum;
`ifdef ARB_STATS_EN
  logic [NREQ-1:0][15:0] grant_cnt;
`endif

  adder64_rr_sched #(.NREQ(NREQ), .ADDER_LAT(LAT), .IDW(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .drain(drain), .idle(idle),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum)
`ifdef ARB_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Adder model: operands captured when the issue strobe is sampled, then LAT stages.
  logic [63:0] apipe [0:LAT];
  always @(posedge clk) begin
    apipe[0] <= add_a + add_b;
    for (int s = 1; s <= LAT; s++) apipe[s] <= apipe[s-1];
  end
  assign add_sum = apipe[LAT];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int edge_n; int id; } hs_t;
  typedef struct { int edge_n; logic [NREQ-1:0] vld; logic [63:0] sum; } rsp_t;
  hs_t  hs_q[$];
  rsp_t rsp_q[$];

  // Inputs change 1ns after posedge, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) hs_q.push_back('{cyc + 1, i});
      if (|rsp_valid) rsp_q.push_back('{cyc, rsp_valid, rsp_sum});
    end
  end

  int nerr = 0, nchk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [63:0] exp_s [NREQ];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; drain = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    req_a[0] = 64'h0000_0000_0000_0001; req_b[0] = 64'h0000_0000_0000_0002;
    req_a[1] = 64'h8000_0000_0000_0000; req_b[1] = 64'h8000_0000_0000_0000;
    req_a[2] = 64'h0123_4567_89AB_CDEF; req_b[2] = 64'h1111_1111_1111_1111;
    req_a[3] = 64'hFFFF_FFFF_0000_0000; req_b[3] = 64'h0000_0001_FFFF_FFFF;
    exp_s[0] = 64'h0000_0000_0000_0003;
    exp_s[1] = 64'h0000_0000_0000_0000;
    exp_s[2] = 64'h1234_5678_9ABC_DF00;
    exp_s[3] = 64'h0000_0000_FFFF_FFFF;

    // Reset with every requester asserting valid
    req_valid = 4'hF;
    step(2);
    chk("rst_ready", req_ready, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_idle", idle, 0);
    rst = 1'b0;
    #1;
    chk("first_grant", req_ready, 4'b0001);
    hs_q.delete(); rsp_q.delete();

    // Contention: all four held for eight grants
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", req_ready, 64'(1) << (k % 4));
      step(1);
    end
    req_valid = '0;
    step(8);
    chk("cont_hs_count", hs_q.size(), 8);
    chk("cont_rsp_count", rsp_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < hs_q.size() && k < rsp_q.size() && rsp_q.size() > 0) begin
        chk("cont_gnt_id", hs_q[k].id, k % 4);
        chk("cont_rsp_vld", rsp_q[k].vld, 64'(1) << (k % 4));
        chk("cont_rsp_sum", rsp_q[k].sum, exp_s[k % 4]);
        chk("cont_latency", rsp_q[k].edge_n - hs_q[k].edge_n, 4);
        chk("cont_b2b", rsp_q[k].edge_n - rsp_q[0].edge_n, k);
      end
    end
    chk("idle_run_empty", idle, 1);

    // Single op with wrap-around
    hs_q.delete(); rsp_q.delete();
    req_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; req_b[0] = 64'h1;
    req_valid = 4'b0001;
    #1;
    chk("single_ready", req_ready, 4'b0001);
    chk("single_not_idle", idle, 0);
    step(1);
    req_valid = '0;
    step(6);
    chk("single_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() == 1 && hs_q.size() == 1) begin
      chk("single_rsp_vld", rsp_q[0].vld, 4'b0001);
      chk("single_rsp_sum", rsp_q[0].sum, 64'h0);
      chk("single_latency", rsp_q[0].edge_n - hs_q[0].edge_n, 4);
    end

    // Drain with two ops in flight and req1 waiting
    hs_q.delete(); rsp_q.delete();
    req_valid = 4'b0001;
    step(2);
    req_valid = 4'b0010;
    drain = 1'b1;
    #1;
    chk("drain_blocks", req_ready, 0);
    n = 0;
    while (!idle && n < 20) begin
      step(1);
      if (req_ready != 0) chk("drain_ready", req_ready, 0);
      n++;
    end
    chk("drain_idle", idle, 1);
    chk("drain_hs_count", hs_q.size(), 2);
    chk("drain_rsp_count", rsp_q.size(), 2);
    if (rsp_q.size() == 2) begin
      chk("drain_rsp0", rsp_q[0].sum, 64'h0);
      chk("drain_rsp1_vld", rsp_q[1].vld, 4'b0001);
    end
    step(2);
    chk("empty_hold_ready", req_ready, 0);
    chk("empty_hold_idle", idle, 1);
    drain = 1'b0;
    #1;
    chk("empty_exit_ready", req_ready, 0);
    step(1);
    chk("resume_grant", req_ready, 4'b0010);
    step(1);
    req_valid = '0;
    step(6);
    chk("resume_rsp_count", rsp_q.size(), 3);
    if (rsp_q.size() == 3) begin
      chk("resume_rsp_vld", rsp_q[2].vld, 4'b0010);
      chk("resume_rsp_sum", rsp_q[2].sum, 64'h0);
    end

    // Reset one cycle after issuing 5+7
    hs_q.delete(); rsp_q.delete();
    req_a[0] = 64'd5; req_b[0] = 64'd7;
    req_valid = 4'b0001;
    step(1);
    req_valid = '0;
    step(1);
    rst = 1'b1;
    rsp_q.delete();
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_add_valid", add_valid, 0);
    step(1);
    rst = 1'b0;
    hs_q.delete();
    step(8);
    chk("midrst_no_rsp", rsp_q.size(), 0);
    req_a[0] = 64'd3; req_b[0] = 64'd4;
    req_valid = 4'b0001;
    #1;
    chk("midrst_first_grant", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    step(6);
    chk("midrst_rsp_count", rsp_q.size(), 1);
    if (rsp_q.size() == 1) begin
      chk("midrst_rsp_sum", rsp_q[0].sum, 64'd7);
      chk("midrst_rsp_vld", rsp_q[0].vld, 4'b0001);
    end

`ifdef ARB_STATS_EN
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("stats_clear", grant_cnt[0], 0);
    req_valid = 4'b0100;
    step(70000);
    req_valid = '0;
    step(1);
    chk("stats_sat2", grant_cnt[2], 16'hFFFF);
    chk("stats_zero0", grant_cnt[0], 0);
    chk("stats_zero1", grant_cnt[1], 0);
    chk("stats_zero3", grant_cnt[3], 0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
